// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and default IO port constants for the UART receive peripheral.
//  rx_state_t          receiver FSM state encoding
//  DEFAULT_DATA_PORT   Address[15:8] of the data (pop) port
//  DEFAULT_STAT_PORT   Address[15:8] of the status port
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam logic [7:0] DEFAULT_DATA_PORT = 8'h03;
    localparam logic [7:0] DEFAULT_STAT_PORT = 8'h04;

endpackage

// File: rtl/uart_rx_io_if.sv
// uart_rx_io_if: Z80 IO read bus as seen by the receive peripheral.
//  Address   CPU A[15:8]
//  IORQ, RD  active-high IO request and read strobe
//  Data_out  read data, 8'h00 when Data_oe=0
//  Data_oe   high while a decoded read cycle is active
//  master = CPU side, slave = peripheral side
interface uart_rx_io_if;
    logic [7:0] Address;
    logic       IORQ;
    logic       RD;
    logic [7:0] Data_out;
    logic       Data_oe;

    modport master (output Address, IORQ, RD, input Data_out, Data_oe);
    modport slave (input Address, IORQ, RD, output Data_out, Data_oe);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous byte FIFO for received frames.
//  clk, reset  clock and asynchronous active-low reset
//  push, din   write request and data; refused only when full with no pop
//  pop         read request; no-op when empty
//  head        entry at the read pointer (valid when !empty)
//  count       number of stored entries
//  full/empty  occupancy flags
module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [7:0] mem [DEPTH];
    logic [AW:0] wrPtr, rdPtr;
    logic doPop, doPush;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign count = wrPtr - rdPtr;
    assign full = count == FULL_CNT;
    assign empty = wrPtr == rdPtr;
    assign head = mem[rdPtr[AW-1:0]];
    assign doPop = pop & !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign doPush = push & (!full | doPop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + ONE;
            if (doPop) rdPtr <= rdPtr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_rx_io.sv
// uart_rx_io: 8N1 serial receiver with a receive FIFO, read through Z80 IO cycles.
//  clk       single clock
//  reset     asynchronous active-low reset
//  uart_rx   serial input, idle high, asynchronous to clk
//  bus       IO read bus (slave): DATA_PORT pops the FIFO head, STAT_PORT returns {5'b0, fe, ovr, rx_ready}
//  rx_ready  high while the FIFO holds data (registered)
module uart_rx_io
    import uart_rx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 87,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] DATA_PORT    = DEFAULT_DATA_PORT,
    parameter logic [7:0] STAT_PORT    = DEFAULT_STAT_PORT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          uart_rx,
    uart_rx_io_if.slave   bus,
    output logic          rx_ready
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_t state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [2:0] bitIdx, bitIdxNext;
    logic [7:0] shift, shiftNext;
    logic rxMeta, rxS;
    logic push, pop, feSet, ovrSet, statClr;
    logic fe, ovr;
    logic rdc, rdcQ, readEnd, dataHit, statHit;
    logic [7:0] addrQ, head;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic full, empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta <= 1'b1;
            rxS <= 1'b1;
            state <= IDLE;
            cnt <= '0;
            bitIdx <= '0;
            shift <= '0;
        end else begin
            rxMeta <= uart_rx;
            rxS <= rxMeta;
            state <= stateNext;
            cnt <= cntNext;
            bitIdx <= bitIdxNext;
            shift <= shiftNext;
        end
    end

    // Start is checked at half a bit, so every later full-bit count lands mid-bit.
    always_comb begin
        stateNext = state;
        cntNext = cnt + CW'(1);
        bitIdxNext = bitIdx;
        shiftNext = shift;
        push = 1'b0;
        feSet = 1'b0;
        case (state)
            IDLE: begin
                cntNext = '0;
                if (!rxS) stateNext = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cntNext = '0;
                    bitIdxNext = '0;
                    stateNext = rxS ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cntNext = '0;
                    shiftNext = {rxS, shift[7:1]};
                    bitIdxNext = bitIdx + 3'd1;
                    if (bitIdx == 3'd7) stateNext = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cntNext = '0;
                    push = rxS;
                    feSet = !rxS;
                    stateNext = rxS ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                cntNext = '0;
                if (rxS) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din(shift),
        .head(head),
        .count(count),
        .full(full),
        .empty(empty)
    );

    assign rdc = bus.IORQ & bus.RD;
    assign dataHit = bus.Address == DATA_PORT;
    assign statHit = bus.Address == STAT_PORT;
    // Side effects use the address captured when the strobe rose.
    assign readEnd = rdcQ & !rdc;
    assign pop = readEnd & (addrQ == DATA_PORT);
    assign statClr = readEnd & (addrQ == STAT_PORT);
    // A pop on a full FIFO always succeeds, so only an unpaired push overflows.
    assign ovrSet = push & full & !pop;

    assign bus.Data_oe = reset & rdc & (dataHit | statHit);
    assign bus.Data_out = !bus.Data_oe ? 8'h00 :
                          dataHit ? (empty ? 8'h00 : head) :
                          {5'b0, fe, ovr, rx_ready};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdcQ <= 1'b0;
            addrQ <= '0;
            fe <= 1'b0;
            ovr <= 1'b0;
            rx_ready <= 1'b0;
        end else begin
            rdcQ <= rdc;
            if (rdc & !rdcQ) addrQ <= bus.Address;
            // A new error in the clearing cycle wins over the clear.
            fe <= feSet | (fe & !statClr);
            ovr <= ovrSet | (ovr & !statClr);
            rx_ready <= count != '0;
        end
    end
endmodule

// File: tb/tb_uart_rx_io.sv
// tb_uart_rx_io: directed frames and IO reads against hand-computed results, CLKS_PER_BIT=8.
module tb_uart_rx_io;
    localparam int CPB = 8;
    localparam logic [7:0] DPORT = 8'h03;
    localparam logic [7:0] SPORT = 8'h04;

    logic clk = 1'b0;
    logic reset;
    logic uart_rx;
    logic rx_ready;
    int vecCount = 0;
    int missCount = 0;

    uart_rx_io_if bus();

    uart_rx_io #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(4),
        .DATA_PORT(DPORT),
        .STAT_PORT(SPORT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .uart_rx(uart_rx),
        .bus(bus),
        .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int lowHold);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stopBit;
        repeat (CPB) @(negedge clk);
        repeat (lowHold) @(negedge clk);
        uart_rx = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    task automatic busRead(input logic [7:0] addr, input int hold,
                           output logic [7:0] d, output logic oe, output logic stable);
        bus.Address = addr;
        bus.IORQ = 1'b1;
        bus.RD = 1'b1;
        #1;
        d = bus.Data_out;
        oe = bus.Data_oe;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (bus.Data_out !== d || bus.Data_oe !== oe) stable = 1'b0;
        end
        bus.IORQ = 1'b0;
        bus.RD = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic readPort(input logic [7:0] addr, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        logic oe, st;
        busRead(addr, 2, d, oe, st);
        checkEq({tag, "_data"}, d, exp);
        checkEq({tag, "_oe"}, {7'b0, oe}, 8'h01);
    endtask

    initial begin
        logic [7:0] burst [5];
        logic [7:0] d;
        logic oe, st;
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        reset = 1'b0;
        uart_rx = 1'b1;
        bus.Address = 8'h00;
        bus.IORQ = 1'b0;
        bus.RD = 1'b0;
        repeat (3) @(negedge clk);
        checkEq("rst_dout", bus.Data_out, 8'h00);
        checkEq("rst_oe", {7'b0, bus.Data_oe}, 8'h00);
        checkEq("rst_ready", {7'b0, rx_ready}, 8'h00);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        sendFrame(8'hA5, 1'b1, 0);
        checkEq("a5_ready", {7'b0, rx_ready}, 8'h01);
        readPort(SPORT, 8'h01, "a5_stat");
        readPort(DPORT, 8'hA5, "a5_pop");
        checkEq("a5_ready_fall", {7'b0, rx_ready}, 8'h00);

        foreach (burst[i]) sendFrame(burst[i], 1'b1, 0);
        readPort(SPORT, 8'h03, "ovr_stat");
        for (int i = 0; i < 4; i++) readPort(DPORT, burst[i], "ovr_pop");
        readPort(SPORT, 8'h00, "ovr_clr");
        readPort(DPORT, 8'h00, "empty_pop");

        sendFrame(8'h5A, 1'b0, 40);
        checkEq("brk_ready", {7'b0, rx_ready}, 8'h00);
        readPort(SPORT, 8'h04, "brk_stat");
        sendFrame(8'h3C, 1'b1, 0);
        readPort(SPORT, 8'h01, "post_brk_stat");
        readPort(DPORT, 8'h3C, "post_brk_pop");
        readPort(SPORT, 8'h00, "post_brk_empty");

        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        readPort(SPORT, 8'h00, "glitch_stat");

        sendFrame(8'h81, 1'b1, 0);
        sendFrame(8'h42, 1'b1, 0);
        busRead(DPORT, 6, d, oe, st);
        checkEq("long_data", d, 8'h81);
        checkEq("long_oe", {7'b0, oe}, 8'h01);
        checkEq("long_stable", {7'b0, st}, 8'h01);
        checkEq("long_ready", {7'b0, rx_ready}, 8'h01);
        readPort(DPORT, 8'h42, "long_next");
        readPort(SPORT, 8'h00, "long_empty");

        sendFrame(8'h66, 1'b1, 0);
        uart_rx = 1'b0;
        repeat (CPB + 20) @(negedge clk);
        bus.Address = SPORT;
        bus.IORQ = 1'b1;
        bus.RD = 1'b1;
        #1;
        checkEq("pre_rst_stat", bus.Data_out, 8'h01);
        #2;
        reset = 1'b0;
        #1;
        checkEq("mid_rst_dout", bus.Data_out, 8'h00);
        checkEq("mid_rst_oe", {7'b0, bus.Data_oe}, 8'h00);
        checkEq("mid_rst_ready", {7'b0, rx_ready}, 8'h00);
        bus.IORQ = 1'b0;
        bus.RD = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        readPort(SPORT, 8'h00, "post_rst_stat");
        sendFrame(8'h7E, 1'b1, 0);
        readPort(SPORT, 8'h01, "7e_stat");
        readPort(DPORT, 8'h7E, "7e_pop");
        readPort(SPORT, 8'h00, "7e_empty");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
